dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Parametrised data memory with an integrated load/store alignment unit.
//  Takes one load or store request per cycle over a valid/ready handshake.
//  Generates byte lanes from access size and address, and sign- or zero-extends
//  loads. Returns every request's response after a fixed, pipelined latency.
//  Sits between the core's MEM stage and the on-chip data SRAM.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; power of 2, >=16
//  ADDR_W       32    byte-address width of req_addr
//  LATENCY      1     acceptance-to-response cycles, legal 1..4
//  INIT_FILE    ""    hex file loaded with $readmemh at time 0 when non-empty
// PORTS
//  clk           in   1       rising-edge clock
//  rstn          in   1       async active-low reset
//  req_valid     in   1       request present
//  req_ready     out  1       block can accept; req fires when valid&ready
//  req_we        in   1       1=store, 0=load
//  req_size      in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1       load zero-extend (lbu/lhu); ignored for word/store
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   32      store data, right-justified
//  rsp_valid     out  1       response valid, exactly one per fired request
//  rsp_rdata     out  32      extended load data; 0 for stores and errors
//  rsp_err       out  1       request was misaligned/illegal (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rstn=0): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    all pipeline valid bits cleared. RAM contents are not reset.
//  - req_ready is registered; it rises on the first clk edge after rstn
//    deasserts and stays 1. There is no back-pressure on responses.
//  - Word index = req_addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored (aliasing).
//  - Store lanes: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0};
//    word -> 4'b1111. Data is replicated: byte {4{wd[7:0]}}, half {2{wd[15:0]}}.
//  - A store commits on the same edge it fires. A load fired on the next cycle
//    to the same word returns the new data.
//  - A load reads the word on the firing edge. The result shifts right by 8*addr[1:0],
//    then sign-extends from bit 7 or 15 (or zero-extends if req_unsigned).
//  - Response pipeline: LATENCY stages of {valid, rdata, err}. A request fired at
//    edge N gives rsp_valid=1 for exactly one cycle after edge N+LATENCY-1
//    (LATENCY=1: the cycle after the firing edge). Order is strictly preserved.
//    Back-to-back requests give back-to-back responses.
//  - req_size=11 always gives rsp_err=1: no write, rdata=0.
//  - Reset mid-operation drops in-flight responses. Stores already fired
//    remain committed.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined: half with addr[0]=1, or word with
//    addr[1:0]!=0, gives rsp_err=1, suppresses the write and returns rdata=0.
//  Not defined: misaligned addresses are force-aligned (addr[0] cleared for half,
//    addr[1:0] cleared for word), the access proceeds and rsp_err=0.
//  Stores additionally $display "dataaddr = %h, writedata = %h" (word-aligned
//    address, raw wdata) under simulation in both configurations.
// TESTING
//  1 Reset then release: req_ready=0 until first edge after rstn=1;
//    rsp_valid stays 0 with no requests.
//  2 sw 0x8000_00F1 @0x10, then lb @0x10 -> 0xFFFF_FFF1; lbu @0x13 -> 0x80;
//    lh @0x12 -> 0xFFFF_8000; lw -> 0x8000_00F1.
//  3 sw 0 @0x20; sb 0xAB @0x22; sh 0x1234 @0x20; lw @0x20 -> 0x00AB_1234.
//  4 LATENCY=3: 5 back-to-back loads -> 5 consecutive rsp_valid cycles,
//    starting 3 edges after the first fire, data in issue order.
//  5 lw @0x06 with trap macro -> rsp_err=1, rdata=0, RAM unchanged.
//    Without the macro -> word @0x04 returned, err=0.
//  6 Assert rstn=0 with 2 loads in flight (LATENCY=2) -> no rsp_valid for them;
//    a store fired before reset is read back after reset.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: data memory with load/store alignment, sign/zero extension and a fixed-latency response pipe.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module dmem_lsu #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    ADDR_W      = 32,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IW = $clog2(DEPTH_WORDS);

    logic [31:0]        mem [DEPTH_WORDS];
    logic               fire, bad, wr;
    logic [1:0]         off;
    logic [IW-1:0]      idx;
    logic [3:0]         lanes;
    logic [31:0]        wd, sh, ld_data;
    logic [LATENCY-1:0] pv, pe;
    logic [31:0]        pd [LATENCY];
    logic               unused;

    assign fire   = req_valid & req_ready;
    assign idx    = req_addr[IW+1:2];
    assign unused = ^req_addr[ADDR_W-1:IW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign bad = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                 (req_size == 2'b10 & |req_addr[1:0]);
    assign off = req_addr[1:0];
`else
    // Misaligned halves/words are silently aligned down to their natural boundary.
    assign bad = req_size == 2'b11;
    assign off = req_size == 2'b10 ? 2'b00 :
                 req_size == 2'b01 ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif

    assign wr = fire & req_we & ~bad;

    always_comb begin
        lanes   = req_size == 2'b00 ? 4'b0001 << off :
                  req_size == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
        wd      = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                  req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
        sh      = mem[idx] >> {off, 3'b000};
        ld_data = req_size == 2'b00 ? {{24{sh[7] & ~req_unsigned}}, sh[7:0]} :
                  req_size == 2'b01 ? {{16{sh[15] & ~req_unsigned}}, sh[15:0]} : sh;
    end

    always_ff @(posedge clk) begin
        if (wr)
            for (int b = 0; b < 4; b++)
                if (lanes[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_ready <= 1'b0;
            pv        <= '0;
            pe        <= '0;
            for (int i = 0; i < LATENCY; i++) pd[i] <= '0;
        end else begin
            req_ready <= 1'b1;
            pv[0]     <= fire;
            pe[0]     <= fire & bad;
            pd[0]     <= (fire & ~req_we & ~bad) ? ld_data : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign rsp_valid = pv[LATENCY-1];
    assign rsp_err   = pe[LATENCY-1];
    assign rsp_rdata = pd[LATENCY-1];

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (fire & req_we)
            $display("dataaddr = %h, writedata = %h", {req_addr[ADDR_W-1:2], 2'b00}, req_wdata);
    end
`endif
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: three dmem_lsu instances (LATENCY 1/3/2) share one request stream; a scoreboard checks each.
module tb_dmem_lsu;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int LAT [3] = '{1, 3, 2};

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          fc;
    } exp_t;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  ready, rv, re;
    logic [31:0] rd [3];
    logic [7:0]  bm [4096];
    exp_t        q[$];
    int          h [3] = '{0, 0, 0};
    int          cyc = 0, errors = 0, checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_lsu #(.LATENCY(1)) u_l1 (.clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(ready[0]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]));
    dmem_lsu #(.LATENCY(3)) u_l3 (.clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(ready[1]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]));
    dmem_lsu #(.LATENCY(2)) u_l2 (.clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(ready[2]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(re[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-addressed reference of the memory; aliasing comes from keeping only addr[11:0].
    task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] r, output logic e);
        logic [11:0] b;
        int n;
        b = a[11:0];
        e = sz == 2'b11;
        if (TRAP) begin
            if ((sz == 2'b01 && b[0]) || (sz == 2'b10 && b[1:0] != 2'b00)) e = 1'b1;
        end else begin
            if (sz == 2'b01) b[0] = 1'b0;
            if (sz == 2'b10) b[1:0] = 2'b00;
        end
        r = '0;
        n = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
        if (!e) begin
            if (we) begin
                for (int k = 0; k < n; k++) bm[int'(b) + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) r[8*k +: 8] = bm[int'(b) + k];
                if (!uns && n == 1) r[31:8] = {24{r[7]}};
                if (!uns && n == 2) r[31:16] = {16{r[15]}};
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input bit use_exp, input logic [31:0] xrd, input logic xerr);
        logic [31:0] mrd;
        logic        merr;
        exp_t        e;
        model(we, sz, uns, a, wd, mrd, merr);
        check("req_ready", {29'b0, ready}, 32'h7);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        e.rd = use_exp ? xrd : mrd;
        e.err = use_exp ? xerr : merr;
        e.fc = cyc;
        q.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        issue(1'b1, sz, 1'b0, a, wd, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] x);
        issue(1'b0, sz, uns, a, 32'h0, 1'b1, x, 1'b0);
    endtask

    task automatic mon();
        for (int i = 0; i < 3; i++) begin
            bit pend;
            int due;
            pend = h[i] < q.size();
            due  = pend ? q[h[i]].fc + LAT[i] - 1 : 0;
            check($sformatf("rsp_valid_L%0d", LAT[i]), {31'b0, rv[i]}, {31'b0, pend && due <= cyc});
            if (rv[i] && pend) begin
                check($sformatf("rsp_rdata_L%0d", LAT[i]), rd[i], q[h[i]].rd);
                check($sformatf("rsp_err_L%0d", LAT[i]), {31'b0, re[i]}, {31'b0, q[h[i]].err});
                h[i]++;
            end
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon();
            end
        join_none

        // Reset values, then req_ready rises only on the first edge after release.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", {31'b0, ready[i]}, 32'h0);
            check("rst_valid", {31'b0, rv[i]}, 32'h0);
            check("rst_rdata", rd[i], 32'h0);
            check("rst_err", {31'b0, re[i]}, 32'h0);
        end
        #1 rstn = 1'b1;
        #1 check("ready_before_edge", {29'b0, ready}, 32'h0);
        @(posedge clk); #1;
        check("ready_after_edge", {29'b0, ready}, 32'h7);
        repeat (3) @(posedge clk);
        #1;

        st(2'b10, 32'h10, 32'h8000_00F1);
        ld(2'b00, 1'b0, 32'h10, 32'hFFFF_FFF1);
        ld(2'b00, 1'b1, 32'h13, 32'h0000_0080);
        ld(2'b01, 1'b0, 32'h12, 32'hFFFF_8000);
        ld(2'b10, 1'b0, 32'h10, 32'h8000_00F1);
        ld(2'b10, 1'b0, 32'h1010, 32'h8000_00F1);

        st(2'b10, 32'h20, 32'h0);
        st(2'b00, 32'h22, 32'h0000_00AB);
        st(2'b01, 32'h20, 32'h0000_1234);
        ld(2'b10, 1'b0, 32'h20, 32'h00AB_1234);
        ld(2'b01, 1'b1, 32'h22, 32'h0000_00AB);
        ld(2'b00, 1'b0, 32'h22, 32'hFFFF_FFAB);
        issue(1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0, 1'b1);
        ld(2'b10, 1'b0, 32'h20, 32'h00AB_1234);

        st(2'b10, 32'h04, 32'h1122_3344);
        issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, TRAP ? 32'h0 : 32'h1122_3344, TRAP);
        issue(1'b1, 2'b10, 1'b0, 32'h06, 32'hDEAD_BEEF, 1'b1, 32'h0, TRAP);
        ld(2'b10, 1'b0, 32'h04, TRAP ? 32'h1122_3344 : 32'hDEAD_BEEF);
        issue(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 1'b1, TRAP ? 32'h0 : 32'hFFFF_BEEF, TRAP);

        // Five back-to-back loads: each instance must answer on consecutive cycles, in order.
        ld(2'b10, 1'b0, 32'h10, 32'h8000_00F1);
        ld(2'b10, 1'b0, 32'h20, 32'h00AB_1234);
        ld(2'b10, 1'b0, 32'h04, TRAP ? 32'h1122_3344 : 32'hDEAD_BEEF);
        ld(2'b00, 1'b0, 32'h10, 32'hFFFF_FFF1);
        ld(2'b01, 1'b1, 32'h20, 32'h0000_1234);
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) issue(1'b1, 2'b10, 1'b0, 32'h100 + 4 * i, $urandom, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 40; i++)
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'h100 + $urandom_range(0, 31), $urandom, 1'b0, 32'h0, 1'b0);

        // Reset with loads in flight: their responses vanish, the earlier stores survive.
        st(2'b10, 32'h40, 32'hCAFE_F00D);
        st(2'b10, 32'h44, 32'h0BAD_C0DE);
        ld(2'b10, 1'b0, 32'h40, 32'hCAFE_F00D);
        ld(2'b10, 1'b0, 32'h44, 32'h0BAD_C0DE);
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) h[i] = q.size();
        #1;
        for (int i = 0; i < 3; i++) begin
            check("midrst_valid", {31'b0, rv[i]}, 32'h0);
            check("midrst_rdata", rd[i], 32'h0);
        end
        repeat (3) @(posedge clk);
        #1 check("midrst_ready", {29'b0, ready}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        #1 check("rerelease_ready", {29'b0, ready}, 32'h0);
        @(posedge clk); #1;
        ld(2'b10, 1'b0, 32'h40, 32'hCAFE_F00D);
        ld(2'b10, 1'b0, 32'h44, 32'h0BAD_C0DE);

        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("drained_L%0d", LAT[i]), h[i], q.size());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
